// File: rtl/mux_n1_pipe_pkg.sv
// Shared constants and helpers for the N:1 pipelined mux.
// Optional parity output is enabled by defining MUX_N1_PIPE_PARITY_EN.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_n1_pipe_if.sv
// Producer/consumer bundle for mux_n1_pipe; slave is the mux side.
// out_par exists only when MUX_N1_PIPE_PARITY_EN is defined.
interface mux_n1_pipe_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8
);
    import mux_pkg::*;
    localparam int SEL_W = clog2_min1(N_CH);

    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_valid;
    logic                   out_ready;
`ifdef MUX_N1_PIPE_PARITY_EN
    logic                   out_par;
`endif

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
`ifdef MUX_N1_PIPE_PARITY_EN
        input  out_par,
`endif
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
`ifdef MUX_N1_PIPE_PARITY_EN
        output out_par,
`endif
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mux_n1_pipe_rr_arb.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    int idx;

    // Scan farthest offset first so the nearest requester after ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N_CH;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_n1_pipe.sv
// N:1 valid/ready mux with one registered output stage, fixed or round-robin select.
// Define MUX_N1_PIPE_PARITY_EN to add the registered out_par output.
module mux_n1_pipe
    import mux_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2_min1(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    mux_n1_pipe_if.slave  bus
);

    localparam int SEL_SPAN = 1 << SEL_W;

    logic                load;
    logic [SEL_SPAN-1:0] valid_ext;
    logic                fix_valid;
    logic                rr_valid;
    logic [SEL_W-1:0]    rr_idx;
    logic                gnt_valid;
    logic [SEL_W-1:0]    gnt;
    logic [DATA_W-1:0]   gnt_data;
    logic [SEL_W-1:0]    ptr;
    logic [DATA_W-1:0]   data_q;
    logic [SEL_W-1:0]    ch_q;
    logic                valid_q;

    mux_rr_arb #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
        .req       (bus.in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    assign load = !valid_q || bus.out_ready;

    // Zero-padded valid vector makes out-of-range sel decode to "no grant".
    always_comb begin
        valid_ext              = '0;
        valid_ext[N_CH-1:0]    = bus.in_valid;
    end

    assign fix_valid = valid_ext[bus.sel];
    assign gnt_valid = (bus.mode == MODE_RR) ? rr_valid : fix_valid;
    assign gnt       = (bus.mode == MODE_RR) ? rr_idx   : bus.sel;

    always_comb begin
        gnt_data     = '0;
        bus.in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt == SEL_W'(k)) begin
                gnt_data        = bus.in_data[k*DATA_W +: DATA_W];
                bus.in_ready[k] = load && gnt_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr     <= SEL_W'(N_CH - 1);
        end else if (load) begin
            if (gnt_valid) begin
                valid_q <= 1'b1;
                data_q  <= gnt_data;
                ch_q    <= gnt;
                if (bus.mode == MODE_RR) ptr <= gnt;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef MUX_N1_PIPE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     par_q <= 1'b0;
        else if (load && gnt_valid)  par_q <= ^gnt_data;
    end

    assign bus.out_par = par_q;
`endif

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Directed bench for mux_n1_pipe: per-cycle reference model plus literal checks.
// Parity checks are compiled in with MUX_N1_PIPE_PARITY_EN.
module tb_mux_n1_pipe;

    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_n1_pipe_if #(.N_CH(N), .DATA_W(W)) bus  ();
    mux_n1_pipe_if #(.N_CH(6), .DATA_W(W)) bus6 ();

    mux_n1_pipe #(.N_CH(N), .DATA_W(W)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    mux_n1_pipe #(.N_CH(6), .DATA_W(W)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state is what the outputs must show after the coming edge.
    bit          m_valid;
    logic [7:0]  m_data;
    int          m_ch;
    int          m_ptr;
    bit          m_par;
    int          g;
    bit          m_load;
    logic [7:0]  exp_rdy;

    always @(negedge clk) begin
        if (rst) begin
            m_valid = 0; m_data = 8'h00; m_ch = 0; m_ptr = N - 1; m_par = 0;
        end else begin
            m_load = !m_valid || bus.out_ready;
            g = -1;
            if (bus.mode == 1'b0) begin
                if (int'(bus.sel) < N && bus.in_valid[bus.sel]) g = int'(bus.sel);
            end else begin
                for (int i = 1; i <= N; i++)
                    if (g < 0 && bus.in_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
            exp_rdy = (m_load && g >= 0) ? 8'(1 << g) : 8'h00;
            chk("model out_valid", 64'(bus.out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("model out_data", 64'(bus.out_data), 64'(m_data));
                chk("model out_ch", 64'(bus.out_ch), 64'(m_ch));
            end
            chk("model in_ready", 64'(bus.in_ready), 64'(exp_rdy));
`ifdef MUX_N1_PIPE_PARITY_EN
            chk("model out_par", 64'(bus.out_par), 64'(m_par));
`endif
            if (m_load) begin
                if (g >= 0) begin
                    m_valid = 1;
                    m_data  = bus.in_data[g*W +: W];
                    m_par   = ^bus.in_data[g*W +: W];
                    m_ch    = g;
                    if (bus.mode) m_ptr = g;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_seq2 [4] = '{2, 6, 2, 6};

    initial begin
        bus.in_data = '0; bus.in_valid = '0; bus.mode = 1'b0; bus.sel = '0; bus.out_ready = 1'b0;
        bus6.in_data = '0; bus6.in_valid = '0; bus6.mode = 1'b0; bus6.sel = '0; bus6.out_ready = 1'b0;
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 8'(8'h10 + k);
        for (int k = 0; k < 6; k++) bus6.in_data[k*W +: W] = 8'(8'h20 + k);

        step(); step();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data", 64'(bus.out_data), 64'd0);
        chk("reset out_ch", 64'(bus.out_ch), 64'd0);
        rst = 1'b0;

        // Fixed select of channel 5.
        bus.in_valid = 8'hFF; bus.sel = 3'd5; bus.out_ready = 1'b1;
        #1 chk("fixed in_ready", 64'(bus.in_ready), 64'h20);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("fixed out_data", 64'(bus.out_data), 64'h15);
            chk("fixed out_ch", 64'(bus.out_ch), 64'd5);
            chk("fixed in_ready cycle", 64'(bus.in_ready), 64'h20);
        end

        // Round-robin from reset, all requesting.
        rst = 1'b1; step(); rst = 1'b0; bus.mode = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
            chk("rr all out_valid", 64'(bus.out_valid), 64'd1);
            chk("rr all out_ch", 64'(bus.out_ch), 64'(c % 8));
        end

        // Two requesters, then a sole requester.
        bus.in_valid = 8'b0100_0100;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rr pair out_ch", 64'(bus.out_ch), 64'(exp_seq2[c]));
        end
        bus.in_valid = 8'b0100_0000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rr sole out_valid", 64'(bus.out_valid), 64'd1);
            chk("rr sole out_ch", 64'(bus.out_ch), 64'd6);
        end

        // Backpressure while holding ch3; sel moves to 4 during the stall.
        bus.mode = 1'b0; bus.sel = 3'd3; bus.in_valid = 8'hFF;
        step();
        chk("bp setup out_ch", 64'(bus.out_ch), 64'd3);
        bus.out_ready = 1'b0; bus.sel = 3'd4;
        for (int c = 0; c < 4; c++) begin
            #1 chk("bp in_ready", 64'(bus.in_ready), 64'h00);
            step();
            chk("bp out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp out_ch hold", 64'(bus.out_ch), 64'd3);
            chk("bp out_data hold", 64'(bus.out_data), 64'h13);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp release in_ready", 64'(bus.in_ready), 64'h10);
        step();
        chk("bp release out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp release out_ch", 64'(bus.out_ch), 64'd4);

        // Six-channel instance, out-of-range select.
        bus6.in_valid = 6'h3F; bus6.sel = 3'd0; bus6.out_ready = 1'b1;
        step();
        chk("n6 first out_valid", 64'(bus6.out_valid), 64'd1);
        chk("n6 first out_data", 64'(bus6.out_data), 64'h20);
        bus6.sel = 3'd7;
        #1 chk("n6 sel7 in_ready", 64'(bus6.in_ready), 64'h00);
        chk("n6 sel7 draining", 64'(bus6.out_valid), 64'd1);
        step();
        chk("n6 sel7 out_valid", 64'(bus6.out_valid), 64'd0);
        bus6.sel = 3'd6;
        #1 chk("n6 sel6 in_ready", 64'(bus6.in_ready), 64'h00);
        step();
        chk("n6 sel6 out_valid", 64'(bus6.out_valid), 64'd0);

        // Asynchronous reset in the middle of a streaming cycle.
        bus.mode = 1'b1;
        step(); step();
        chk("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", 64'(bus.out_valid), 64'd0);
        chk("async out_data", 64'(bus.out_data), 64'd0);
        chk("async out_ch", 64'(bus.out_ch), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("post-reset out_ch", 64'(bus.out_ch), 64'd0);
        chk("post-reset out_valid", 64'(bus.out_valid), 64'd1);

`ifdef MUX_N1_PIPE_PARITY_EN
        bus.mode = 1'b0; bus.sel = 3'd7; bus.in_data[7*W +: W] = 8'h07;
        step();
        chk("parity out_data", 64'(bus.out_data), 64'h07);
        chk("parity out_par", 64'(bus.out_par), 64'd1);
        bus.sel = 3'd3;
        step();
        chk("parity even out_par", 64'(bus.out_par), 64'd1);
        bus.sel = 3'd0;
        step();
        chk("parity ch0 out_par", 64'(bus.out_par), 64'd1);
        bus.in_data[0*W +: W] = 8'h11;
        step();
        chk("parity zero out_par", 64'(bus.out_par), 64'd0);
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
